// File: rtl/monitor_capture_buffer.sv
// Multi-channel monitor capture buffer: each channel arms on an enable rising edge,
// averages 2^AVG_LOG2 tagged ADC results and holds the floor average with a valid flag.
module monitor_capture_buffer #(
  parameter int WIDTH    = 16,
  parameter int NCH      = 4,
  parameter int CHW      = 2,
  parameter int AVG_LOG2 = 2
) (
  input  logic             SAMPLE_CLK,
  input  logic             NRST_sync,
  input  logic [NCH-1:0]   ENMON_sync,
  input  logic             DONE,
  input  logic [CHW-1:0]   RESULT_CH,
  input  logic [WIDTH-1:0] RESULT,
  input  logic [CHW-1:0]   RD_CH,
  output logic [WIDTH-1:0] RD_VAL,
  output logic [NCH-1:0]   VALID,
  output logic [NCH-1:0]   BUSY,
  output logic [2*NCH-1:0] state_dbg_o
);

  localparam int AW   = WIDTH + AVG_LOG2;
  localparam int CNTW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HELD  = 2'd2
  } state_e;

  logic [WIDTH-1:0] held_arr [NCH];

  // DONE/RESULT_CH/RESULT form a one-cycle strobe with no backpressure: a result is
  // consumed in the DONE cycle by the tagged channel if it is armed, otherwise dropped.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_e           state_q;
    logic             en_q;
    logic             arm_ok_q;
    logic             valid_q;
    logic             busy_q;
    logic [AW-1:0]    acc_q;
    logic [CNTW-1:0]  cnt_q;
    logic [WIDTH-1:0] held_q;

    logic             rise;
    logic             hit;
    logic             last;
    logic [AW-1:0]    sum;

    // arm_ok_q blocks arming after reset until the enable has been seen low once,
    // so an enable held high through reset does not look like a fresh edge.
    assign rise = ENMON_sync[c] & ~en_q & arm_ok_q;
    assign hit  = (state_q == ST_ARMED) & DONE & (RESULT_CH == CHW'(c)) & ENMON_sync[c];
    assign last = (cnt_q == CNT_LAST);
    assign sum  = acc_q + AW'(RESULT);

    always_ff @(posedge SAMPLE_CLK or negedge NRST_sync) begin
      if (!NRST_sync) begin
        state_q  <= ST_IDLE;
        en_q     <= 1'b0;
        arm_ok_q <= 1'b0;
        valid_q  <= 1'b0;
        busy_q   <= 1'b0;
        acc_q    <= '0;
        cnt_q    <= '0;
        held_q   <= '0;
      end else begin
        en_q     <= ENMON_sync[c];
        arm_ok_q <= arm_ok_q | ~ENMON_sync[c];
        if (!ENMON_sync[c]) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          acc_q   <= '0;
          cnt_q   <= '0;
        end else if (rise) begin
          state_q <= ST_ARMED;
          busy_q  <= 1'b1;
          valid_q <= 1'b0;
          acc_q   <= '0;
          cnt_q   <= '0;
        end else if (hit) begin
          if (last) begin
            held_q  <= WIDTH'(sum >> AVG_LOG2);
            valid_q <= 1'b1;
            state_q <= ST_HELD;
            busy_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
          end else begin
            acc_q <= sum;
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
      end
    end

    assign VALID[c]             = valid_q;
    assign BUSY[c]              = busy_q;
    assign held_arr[c]          = held_q;
    assign state_dbg_o[2*c +: 2] = state_q;
  end

  always_comb begin
    RD_VAL = '0;
    if (int'(RD_CH) < NCH) begin
      RD_VAL = held_arr[RD_CH];
    end
  end

endmodule

// File: tb/tb_monitor_capture_buffer.sv
// Directed bench for monitor_capture_buffer: an averaging build (AVG_LOG2=2, NCH=4)
// and a one-shot build (AVG_LOG2=0, NCH=3) share clock and reset.
module tb_monitor_capture_buffer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  en;
  logic        done;
  logic [1:0]  tag;
  logic [15:0] res;
  logic [1:0]  rd_ch;
  logic [15:0] rd_val;
  logic [3:0]  valid;
  logic [3:0]  busy;
  logic [7:0]  dbg;

  logic [2:0]  en0;
  logic        done0;
  logic [1:0]  tag0;
  logic [15:0] res0;
  logic [1:0]  rd_ch0;
  logic [15:0] rd_val0;
  logic [2:0]  valid0;
  logic [2:0]  busy0;
  logic [5:0]  dbg0;

  int n_vec;
  int n_err;

  monitor_capture_buffer #(.WIDTH(16), .NCH(4), .CHW(2), .AVG_LOG2(2)) dut (
    .SAMPLE_CLK (clk),
    .NRST_sync  (rst_n),
    .ENMON_sync (en),
    .DONE       (done),
    .RESULT_CH  (tag),
    .RESULT     (res),
    .RD_CH      (rd_ch),
    .RD_VAL     (rd_val),
    .VALID      (valid),
    .BUSY       (busy),
    .state_dbg_o(dbg)
  );

  monitor_capture_buffer #(.WIDTH(16), .NCH(3), .CHW(2), .AVG_LOG2(0)) dut0 (
    .SAMPLE_CLK (clk),
    .NRST_sync  (rst_n),
    .ENMON_sync (en0),
    .DONE       (done0),
    .RESULT_CH  (tag0),
    .RESULT     (res0),
    .RD_CH      (rd_ch0),
    .RD_VAL     (rd_val0),
    .VALID      (valid0),
    .BUSY       (busy0),
    .state_dbg_o(dbg0)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks: inputs change on the falling edge, outputs are read there too
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [1:0] t, input logic [15:0] v);
    done = 1'b1;
    tag  = t;
    res  = v;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic pulse0(input logic [1:0] t, input logic [15:0] v);
    done0 = 1'b1;
    tag0  = t;
    res0  = v;
    @(negedge clk);
    done0 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = '0; done = 1'b0; tag = '0; res = '0; rd_ch = '0;
    en0 = '0; done0 = 1'b0; tag0 = '0; res0 = '0; rd_ch0 = '0;
    #12;
    for (int i = 0; i < 4; i++) begin
      rd_ch = 2'(i);
      #1;
      n_vec++;
      if (rd_val !== 16'h0000) begin
        n_err++;
        $display("FAIL reset_rd_val ch%0d got %h want 0000", i, rd_val);
      end
    end
    n_vec++;
    if (valid !== 4'b0000 || busy !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags valid=%b busy=%b want 0000/0000", valid, busy);
    end
    n_vec++;
    if (valid0 !== 3'b000 || busy0 !== 3'b000 || rd_val0 !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_oneshot valid=%b busy=%b rd=%h want 000/000/0000", valid0, busy0, rd_val0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_average();
    en[1] = 1'b1;
    tick();
    n_vec++;
    if (busy !== 4'b0010 || dbg[3:2] !== 2'd1) begin
      n_err++;
      $display("FAIL avg_arm busy=%b st=%0d want 0010/1", busy, dbg[3:2]);
    end
    pulse(2'd1, 16'd100);
    pulse(2'd1, 16'd101);
    pulse(2'd1, 16'd102);
    n_vec++;
    if (valid[1] !== 1'b0 || busy[1] !== 1'b1) begin
      n_err++;
      $display("FAIL avg_partial valid=%b busy=%b want 0/1", valid[1], busy[1]);
    end
    pulse(2'd1, 16'd104);
    rd_ch = 2'd1;
    #1;
    n_vec++;
    if (rd_val !== 16'd101 || valid !== 4'b0010 || busy !== 4'b0000) begin
      n_err++;
      $display("FAIL avg_capture rd=%0d valid=%b busy=%b want 101/0010/0000", rd_val, valid, busy);
    end
    pulse(2'd1, 16'd900);
    n_vec++;
    if (rd_val !== 16'd101 || valid[1] !== 1'b1) begin
      n_err++;
      $display("FAIL avg_held rd=%0d valid=%b want 101/1", rd_val, valid[1]);
    end
  endtask

  task automatic test_interleave();
    en[0] = 1'b1;
    en[2] = 1'b1;
    tick();
    pulse(2'd0, 16'd10);
    pulse(2'd2, 16'd1000);
    pulse(2'd3, 16'hFFFF);
    pulse(2'd0, 16'd20);
    pulse(2'd2, 16'd1001);
    pulse(2'd1, 16'd7);
    pulse(2'd0, 16'd30);
    pulse(2'd2, 16'd1002);
    n_vec++;
    if (busy !== 4'b0101 || valid !== 4'b0010) begin
      n_err++;
      $display("FAIL ilv_mid busy=%b valid=%b want 0101/0010", busy, valid);
    end
    pulse(2'd0, 16'd41);
    n_vec++;
    if (busy !== 4'b0100 || valid !== 4'b0011) begin
      n_err++;
      $display("FAIL ilv_ch0_done busy=%b valid=%b want 0100/0011", busy, valid);
    end
    pulse(2'd2, 16'd1003);
    rd_ch = 2'd0;
    #1;
    n_vec++;
    if (rd_val !== 16'd25) begin
      n_err++;
      $display("FAIL ilv_ch0 rd=%0d want 25", rd_val);
    end
    rd_ch = 2'd2;
    #1;
    n_vec++;
    if (rd_val !== 16'd1001) begin
      n_err++;
      $display("FAIL ilv_ch2 rd=%0d want 1001", rd_val);
    end
    rd_ch = 2'd1;
    #1;
    n_vec++;
    if (rd_val !== 16'd101 || valid !== 4'b0111 || busy !== 4'b0000) begin
      n_err++;
      $display("FAIL ilv_ch1 rd=%0d valid=%b busy=%b want 101/0111/0000", rd_val, valid, busy);
    end
  endtask

  task automatic test_edge_cases();
    rd_ch = 2'd0;
    en[0] = 1'b0;
    tick();
    n_vec++;
    if (valid !== 4'b0111 || rd_val !== 16'd25) begin
      n_err++;
      $display("FAIL edge_disable_keep valid=%b rd=%0d want 0111/25", valid, rd_val);
    end
    // enable edge coincides with a DONE for ch0; that DONE must be dropped
    en[0] = 1'b1;
    pulse(2'd0, 16'd60000);
    n_vec++;
    if (valid[0] !== 1'b0 || busy[0] !== 1'b1 || rd_val !== 16'd25) begin
      n_err++;
      $display("FAIL edge_rearm valid=%b busy=%b rd=%0d want 0/1/25", valid[0], busy[0], rd_val);
    end
    pulse(2'd0, 16'd4);
    pulse(2'd0, 16'd8);
    pulse(2'd0, 16'd12);
    n_vec++;
    if (valid[0] !== 1'b0 || rd_val !== 16'd25) begin
      n_err++;
      $display("FAIL edge_done_on_rise valid=%b rd=%0d want 0/25", valid[0], rd_val);
    end
    pulse(2'd0, 16'd16);
    n_vec++;
    if (valid[0] !== 1'b1 || busy[0] !== 1'b0 || rd_val !== 16'd10) begin
      n_err++;
      $display("FAIL edge_new_avg valid=%b busy=%b rd=%0d want 1/0/10", valid[0], busy[0], rd_val);
    end
    en[0] = 1'b0;
    tick();
    en[0] = 1'b1;
    tick();
    n_vec++;
    if (valid[0] !== 1'b0 || busy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL edge_valid_clear valid=%b busy=%b want 0/1", valid[0], busy[0]);
    end
    pulse(2'd0, 16'd1);
    pulse(2'd0, 16'd2);
    pulse(2'd0, 16'd3);
    // disable in the same cycle as the final DONE
    en[0] = 1'b0;
    pulse(2'd0, 16'd1000);
    n_vec++;
    if (valid[0] !== 1'b0 || busy[0] !== 1'b0 || rd_val !== 16'd10) begin
      n_err++;
      $display("FAIL edge_disable_wins valid=%b busy=%b rd=%0d want 0/0/10", valid[0], busy[0], rd_val);
    end
    en[0] = 1'b1;
    tick();
    pulse(2'd0, 16'd40);
    pulse(2'd0, 16'd40);
    pulse(2'd0, 16'd40);
    pulse(2'd0, 16'd43);
    n_vec++;
    if (valid[0] !== 1'b1 || rd_val !== 16'd40) begin
      n_err++;
      $display("FAIL edge_recapture valid=%b rd=%0d want 1/40", valid[0], rd_val);
    end
  endtask

  task automatic test_one_shot();
    en0 = 3'b111;
    tick();
    n_vec++;
    if (busy0 !== 3'b111 || valid0 !== 3'b000) begin
      n_err++;
      $display("FAIL os_arm busy=%b valid=%b want 111/000", busy0, valid0);
    end
    pulse0(2'd3, 16'h5555);
    rd_ch0 = 2'd3;
    #1;
    n_vec++;
    if (valid0 !== 3'b000 || busy0 !== 3'b111 || rd_val0 !== 16'h0000) begin
      n_err++;
      $display("FAIL os_bad_tag valid=%b busy=%b rd=%h want 000/111/0000", valid0, busy0, rd_val0);
    end
    pulse0(2'd2, 16'hFFFF);
    rd_ch0 = 2'd2;
    #1;
    n_vec++;
    if (rd_val0 !== 16'hFFFF || valid0 !== 3'b100) begin
      n_err++;
      $display("FAIL os_capture rd=%h valid=%b want ffff/100", rd_val0, valid0);
    end
    pulse0(2'd2, 16'h1234);
    n_vec++;
    if (rd_val0 !== 16'hFFFF) begin
      n_err++;
      $display("FAIL os_ignore rd=%h want ffff", rd_val0);
    end
    pulse0(2'd0, 16'h0042);
    rd_ch0 = 2'd0;
    #1;
    n_vec++;
    if (rd_val0 !== 16'h0042 || valid0 !== 3'b101) begin
      n_err++;
      $display("FAIL os_ch0 rd=%h valid=%b want 0042/101", rd_val0, valid0);
    end
  endtask

  task automatic test_reset_mid();
    en[3] = 1'b1;
    tick();
    pulse(2'd3, 16'd500);
    pulse(2'd3, 16'd500);
    n_vec++;
    if (busy[3] !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_armed busy=%b want 1", busy[3]);
    end
    rst_n = 1'b0;
    rd_ch = 2'd1;
    #1;
    n_vec++;
    if (valid !== 4'b0000 || busy !== 4'b0000 || rd_val !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_mid_clear valid=%b busy=%b rd=%h want 0000/0000/0000", valid, busy, rd_val);
    end
    tick();
    rst_n = 1'b1;
    tick();
    pulse(2'd3, 16'd700);
    pulse(2'd3, 16'd700);
    pulse(2'd3, 16'd700);
    pulse(2'd3, 16'd700);
    n_vec++;
    if (valid !== 4'b0000 || busy !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_no_rearm valid=%b busy=%b want 0000/0000", valid, busy);
    end
    en[3] = 1'b0;
    tick();
    en[3] = 1'b1;
    tick();
    n_vec++;
    if (busy !== 4'b1000) begin
      n_err++;
      $display("FAIL rst_rearm busy=%b want 1000", busy);
    end
    pulse(2'd3, 16'd700);
    pulse(2'd3, 16'd701);
    pulse(2'd3, 16'd702);
    pulse(2'd3, 16'd703);
    rd_ch = 2'd3;
    #1;
    n_vec++;
    if (rd_val !== 16'd701 || valid !== 4'b1000 || busy !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_recapture rd=%0d valid=%b busy=%b want 701/1000/0000", rd_val, valid, busy);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_average();
    test_interleave();
    test_edge_cases();
    test_one_shot();
    test_reset_mid();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
